// File: rtl/sddr_init_seq.sv
// sddr_init_seq: DDR3 power-up initialisation sequencer.
// Issues a fixed list of control-bus register writes (reset/CKE release,
// MR2/MR3/MR1/MR0 mode-register sets, final switch out of bypass) with
// programmable wait gaps between them, then reports completion.
// Optional feature: define SDDR_INIT_SEQ_ZQCL_EN to insert a ZQCL
// calibration command (A10 address write + ZQCL command + T_ZQINIT_CYC
// wait) after the MR0 wait and before the final write.
module sddr_init_seq #(
    parameter int          BANK_BITS    = 3,
    parameter int          T_RESET_CYC  = 20000,
    parameter int          T_CKE_CYC    = 50000,
    parameter int          T_XPR_CYC    = 128,
    parameter int          T_MOD_CYC    = 12,
    parameter int          T_ZQINIT_CYC = 512,
    parameter logic [15:0] MR0_VAL      = 16'h0000,
    parameter logic [15:0] MR1_VAL      = 16'h0000,
    parameter logic [15:0] MR2_VAL      = 16'h0000,
    parameter logic [15:0] MR3_VAL      = 16'h0000
) (
    input  logic        cpu_clock_i,
    input  logic        reset_i,
    input  logic        start_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        ctrl_cmd_valid,
    output logic [15:0] ctrl_cmd_address,
    output logic [31:0] ctrl_cmd_data,
    output logic        ctrl_cmd_write,
    input  logic        ctrl_cmd_ack
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WR,
        ST_WAIT,
        ST_DONE
    } state_e;

    // Control register map.
    localparam logic [15:0] ADDR_RESET = 16'h0000;
    localparam logic [15:0] ADDR_CMD   = 16'h0004;
    localparam logic [15:0] ADDR_ADDR  = 16'h0008;

    // Index of the final (bypass-release) write in the step list.
`ifdef SDDR_INIT_SEQ_ZQCL_EN
    localparam logic [3:0] LAST_STEP = 4'd13;
`else
    localparam logic [3:0] LAST_STEP = 4'd11;
`endif

    // A wait of zero still costs one cycle so the next write never lands
    // in the cycle right after an ack.
    function automatic logic [31:0] wait_len(input int n);
        return (n > 0) ? 32'(n) : 32'd1;
    endfunction

    // Bank number goes in the top BANK_BITS bits, mode value in [15:0].
    function automatic logic [31:0] mr_word(input logic [1:0] bank, input logic [15:0] val);
        logic [31:0] w;
        w = {16'h0000, val};
        w[31 -: BANK_BITS] = BANK_BITS'(bank);
        return w;
    endfunction

    localparam int W_RESET  = 0;
    localparam int W_CKE    = 1;
    localparam int W_XPR    = 2;
    localparam int W_MOD    = 3;
    localparam int W_ZQINIT = 4;

    localparam logic [31:0] WAIT_LEN [5] = '{
        wait_len(T_RESET_CYC),
        wait_len(T_CKE_CYC),
        wait_len(T_XPR_CYC),
        wait_len(T_MOD_CYC),
        wait_len(T_ZQINIT_CYC)
    };

    state_e      state_q, state_d;
    logic [3:0]  step_q,  step_d;
    logic [31:0] cnt_q,   cnt_d;

    logic [15:0] step_addr;
    logic [31:0] step_data;
    logic [31:0] step_wait;
    logic        step_has_wait;

    // State, step index and wait counter registers.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values; blocking here would create ordering races.
    always_ff @(posedge cpu_clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            step_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            cnt_q   <= cnt_d;
        end
    end

    // Decode the current step into write address, data and following wait.
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case leaves a value unassigned and infers a latch.
    always_comb begin
        step_addr     = ADDR_RESET;
        step_data     = 32'h0000_0000;
        step_wait     = 32'd0;
        step_has_wait = 1'b0;
        case (step_q)
            4'd0: begin
                step_data     = 32'h0000_0000;
                step_wait     = WAIT_LEN[W_RESET];
                step_has_wait = 1'b1;
            end
            4'd1: begin
                step_data     = 32'h0000_0003;
                step_wait     = WAIT_LEN[W_CKE];
                step_has_wait = 1'b1;
            end
            4'd2: begin
                step_data     = 32'h0000_0023;
                step_wait     = WAIT_LEN[W_XPR];
                step_has_wait = 1'b1;
            end
            4'd3: begin
                step_addr = ADDR_ADDR;
                step_data = mr_word(2'd2, MR2_VAL);
            end
            4'd5: begin
                step_addr = ADDR_ADDR;
                step_data = mr_word(2'd3, MR3_VAL);
            end
            4'd7: begin
                step_addr = ADDR_ADDR;
                step_data = mr_word(2'd1, MR1_VAL);
            end
            4'd9: begin
                step_addr = ADDR_ADDR;
                step_data = mr_word(2'd0, MR0_VAL);
            end
            // MRS command after each mode-register address write.
            4'd4, 4'd6, 4'd8, 4'd10: begin
                step_addr     = ADDR_CMD;
                step_data     = 32'h0000_0000;
                step_wait     = WAIT_LEN[W_MOD];
                step_has_wait = 1'b1;
            end
`ifdef SDDR_INIT_SEQ_ZQCL_EN
            4'd11: begin
                step_addr = ADDR_ADDR;
                step_data = 32'h0000_0400;
            end
            4'd12: begin
                step_addr     = ADDR_CMD;
                step_data     = 32'h0000_0006;
                step_wait     = WAIT_LEN[W_ZQINIT];
                step_has_wait = 1'b1;
            end
            4'd13: begin
                step_data = 32'h0000_002B;
            end
`else
            4'd11: begin
                step_data = 32'h0000_002B;
            end
`endif
            default: begin
                step_addr = ADDR_RESET;
            end
        endcase
    end

    // Next-state logic: issue write, wait for ack, count gap, advance step.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    state_d = ST_WR;
                    step_d  = '0;
                end
            end
            ST_WR: begin
                if (ctrl_cmd_ack) begin
                    if (step_q == LAST_STEP) begin
                        state_d = ST_DONE;
                    end else begin
                        step_d = step_q + 4'd1;
                        if (step_has_wait) begin
                            state_d = ST_WAIT;
                            cnt_d   = step_wait;
                        end
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q <= 32'd1) begin
                    state_d = ST_WR;
                    cnt_d   = 32'd0;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs decoded from registered state so reset clears them at once.
    always_comb begin
        busy_o           = (state_q == ST_WR) || (state_q == ST_WAIT);
        done_o           = (state_q == ST_DONE);
        ctrl_cmd_valid   = (state_q == ST_WR);
        ctrl_cmd_write   = (state_q == ST_WR);
        ctrl_cmd_address = (state_q == ST_WR) ? step_addr : 16'h0000;
        ctrl_cmd_data    = (state_q == ST_WR) ? step_data : 32'h0000_0000;
    end

endmodule

// File: tb/tb_sddr_init_seq.sv
// Directed bench for sddr_init_seq: full sequence with immediate ack,
// delayed ack, start while busy / in DONE, reset mid-wait and mid-write,
// and a zero T_MOD_CYC instance for the minimum wait length.
module tb_sddr_init_seq;

`ifdef SDDR_INIT_SEQ_ZQCL_EN
    localparam int N_WR = 14;
    localparam logic [15:0] EXP_ADDR [N_WR] = '{
        16'h0, 16'h0, 16'h0, 16'h8, 16'h4, 16'h8, 16'h4,
        16'h8, 16'h4, 16'h8, 16'h4, 16'h8, 16'h4, 16'h0};
    localparam logic [31:0] EXP_DATA [N_WR] = '{
        32'h0, 32'h3, 32'h23, 32'h40000208, 32'h0, 32'h60000003, 32'h0,
        32'h20000044, 32'h0, 32'h00000D70, 32'h0, 32'h400, 32'h6, 32'h2B};
    localparam int EXP_GAP [N_WR] = '{0, 5, 6, 4, 1, 3, 1, 3, 1, 3, 1, 3, 1, 7};
`else
    localparam int N_WR = 12;
    localparam logic [15:0] EXP_ADDR [N_WR] = '{
        16'h0, 16'h0, 16'h0, 16'h8, 16'h4, 16'h8, 16'h4,
        16'h8, 16'h4, 16'h8, 16'h4, 16'h0};
    localparam logic [31:0] EXP_DATA [N_WR] = '{
        32'h0, 32'h3, 32'h23, 32'h40000208, 32'h0, 32'h60000003, 32'h0,
        32'h20000044, 32'h0, 32'h00000D70, 32'h0, 32'h2B};
    localparam int EXP_GAP [N_WR] = '{0, 5, 6, 4, 1, 3, 1, 3, 1, 3, 1, 3};
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start_a, ack_a, start_b, ack_b;
    logic busy_a, done_a, valid_a, write_a;
    logic [15:0] addr_a;
    logic [31:0] data_a;
    logic busy_b, done_b, valid_b, write_b;
    logic [15:0] addr_b;
    logic [31:0] data_b;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    int wr_cnt_a   = 0;

    sddr_init_seq #(
        .BANK_BITS(3), .T_RESET_CYC(4), .T_CKE_CYC(5), .T_XPR_CYC(3),
        .T_MOD_CYC(2), .T_ZQINIT_CYC(6),
        .MR0_VAL(16'h0D70), .MR1_VAL(16'h0044), .MR2_VAL(16'h0208), .MR3_VAL(16'h0003)
    ) u_dut_a (
        .cpu_clock_i(clk), .reset_i(rst), .start_i(start_a),
        .busy_o(busy_a), .done_o(done_a),
        .ctrl_cmd_valid(valid_a), .ctrl_cmd_address(addr_a), .ctrl_cmd_data(data_a),
        .ctrl_cmd_write(write_a), .ctrl_cmd_ack(ack_a)
    );

    sddr_init_seq #(
        .BANK_BITS(3), .T_RESET_CYC(4), .T_CKE_CYC(5), .T_XPR_CYC(3),
        .T_MOD_CYC(0), .T_ZQINIT_CYC(6),
        .MR0_VAL(16'h0D70), .MR1_VAL(16'h0044), .MR2_VAL(16'h0208), .MR3_VAL(16'h0003)
    ) u_dut_b (
        .cpu_clock_i(clk), .reset_i(rst), .start_i(start_b),
        .busy_o(busy_b), .done_o(done_b),
        .ctrl_cmd_valid(valid_b), .ctrl_cmd_address(addr_b), .ctrl_cmd_data(data_b),
        .ctrl_cmd_write(write_b), .ctrl_cmd_ack(ack_b)
    );

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (valid_a === 1'b1 && ack_a === 1'b1) wr_cnt_a <= wr_cnt_a + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        chk(tag, {31'd0, obs}, {31'd0, exp});
    endtask

    task automatic wait_valid_a(input string tag);
        int t = 0;
        while (valid_a !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk1(tag, valid_a, 1'b1);
    endtask

    task automatic wait_valid_b(input string tag);
        int t = 0;
        while (valid_b !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk1(tag, valid_b, 1'b1);
    endtask

    task automatic pulse_start_a();
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
    endtask

    // Walk the whole write list on instance A. slow: hold ack low 3 cycles
    // per write and check the request stays stable. poke: pulse start while
    // busy after the first write.
    task automatic run_seq(input bit slow, input bit poke);
        int last_cyc = 0;
        int wr0 = wr_cnt_a;
        logic [15:0] held_addr;
        logic [31:0] held_data;
        for (int k = 0; k < N_WR; k++) begin
            wait_valid_a($sformatf("valid_w%0d", k));
            chk($sformatf("addr_w%0d", k), {16'd0, addr_a}, {16'd0, EXP_ADDR[k]});
            chk($sformatf("data_w%0d", k), data_a, EXP_DATA[k]);
            chk1($sformatf("write_w%0d", k), write_a, 1'b1);
            chk1($sformatf("busy_w%0d", k), busy_a, 1'b1);
            if (!slow && k > 0)
                chk($sformatf("gap_w%0d", k), 32'(cyc - last_cyc), 32'(EXP_GAP[k]));
            last_cyc = cyc;
            if (slow) begin
                held_addr = addr_a;
                held_data = data_a;
                for (int h = 0; h < 3; h++) begin
                    @(negedge clk);
                    chk1($sformatf("hold_valid_w%0d", k), valid_a, 1'b1);
                    chk($sformatf("hold_addr_w%0d", k), {16'd0, addr_a}, {16'd0, held_addr});
                    chk($sformatf("hold_data_w%0d", k), data_a, held_data);
                end
                ack_a = 1'b1;
                @(negedge clk);
                ack_a = 1'b0;
            end else begin
                @(negedge clk);
                if (poke && k == 0) begin
                    chk1("busy_in_wait", busy_a, 1'b1);
                    pulse_start_a();
                end
            end
        end
        chk1("done_end", done_a, 1'b1);
        chk1("busy_end", busy_a, 1'b0);
        chk1("valid_end", valid_a, 1'b0);
        chk("write_count", 32'(wr_cnt_a - wr0), 32'(N_WR));
        repeat (4) @(negedge clk);
        chk1("no_extra_write", valid_a, 1'b0);
        chk1("done_held", done_a, 1'b1);
    endtask

    initial begin
        int last_b;
        rst = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        ack_a = 1'b1;
        ack_b = 1'b1;
        repeat (3) @(negedge clk);
        chk1("rst_valid", valid_a, 1'b0);
        chk1("rst_write", write_a, 1'b0);
        chk("rst_addr", {16'd0, addr_a}, 32'd0);
        chk("rst_data", data_a, 32'd0);
        chk1("rst_busy", busy_a, 1'b0);
        chk1("rst_done", done_a, 1'b0);

        // Out of reset with ack held high: no write until start.
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk1("idle_valid", valid_a, 1'b0);
        chk1("idle_busy", busy_a, 1'b0);
        chk1("idle_done", done_a, 1'b0);

        // Full sequence, ack always 1, start poked while busy.
        pulse_start_a();
        run_seq(1'b0, 1'b1);

        // Restart from DONE.
        pulse_start_a();
        chk1("restart_done", done_a, 1'b0);
        chk1("restart_valid", valid_a, 1'b1);
        chk("restart_data", data_a, 32'h0);
        @(negedge clk);
        wait_valid_a("restart_w1_valid");
        chk("restart_w1_data", data_a, 32'h3);
        @(negedge clk);
        @(negedge clk);
        chk1("cke_wait_busy", busy_a, 1'b1);

        // Reset during the CKE wait takes effect without a clock edge.
        rst = 1'b1;
        #1;
        chk1("rst_wait_busy", busy_a, 1'b0);
        chk1("rst_wait_valid", valid_a, 1'b0);
        chk1("rst_wait_done", done_a, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk1("post_rst_valid", valid_a, 1'b0);

        // Reset while a write is pending.
        ack_a = 1'b0;
        pulse_start_a();
        chk("mw_w0_data", data_a, 32'h0);
        ack_a = 1'b1;
        @(negedge clk);
        ack_a = 1'b0;
        wait_valid_a("mw_w1_valid");
        chk("mw_w1_data", data_a, 32'h3);
        @(negedge clk);
        chk1("mw_stall_valid", valid_a, 1'b1);
        rst = 1'b1;
        #1;
        chk1("mw_rst_valid", valid_a, 1'b0);
        chk1("mw_rst_write", write_a, 1'b0);
        chk("mw_rst_data", data_a, 32'h0);
        chk1("mw_rst_busy", busy_a, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Full sequence with ack delayed 3 cycles on every write.
        pulse_start_a();
        run_seq(1'b1, 1'b0);

        // Instance B: zero T_MOD_CYC still gives one wait cycle.
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        last_b = 0;
        for (int k = 0; k < N_WR; k++) begin
            wait_valid_b($sformatf("b_valid_w%0d", k));
            if (k == 5 || k == 7)
                chk($sformatf("b_gap_w%0d", k), 32'(cyc - last_b), 32'd2);
            if (k == 7)
                chk("b_mr1_data", data_b, 32'h20000044);
            last_b = cyc;
            @(negedge clk);
        end
        chk1("b_done", done_b, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/sddr_init_seq.md
SDDR_INIT_SEQ -- requirements
Module: sddr_init_seq

Interface
REQ-001 Params: BANK_BITS 3, bank address width; T_RESET_CYC 20000, reset-hold cycles; T_CKE_CYC 50000, reset-release to CKE cycles; T_XPR_CYC 128, CKE to first MRS cycles; T_MOD_CYC 12, MRS-to-next cycles; T_ZQINIT_CYC 512, ZQCL wait cycles; MR0_VAL..MR3_VAL 16-bit mode-register values, defaults 16'h0000.
REQ-002 Clock/reset decided: one clock; reset is asynchronous and active-high.
REQ-003 cpu_clock_i  in  1  sole clock, rising edge.
REQ-004 reset_i  in  1  async active-high reset.
REQ-005 start_i  in  1  one-cycle pulse, begins init sequence.
REQ-006 busy_o  out  1  sequence in progress.
REQ-007 done_o  out  1  sequence completed, controller out of bypass.
REQ-008 ctrl_cmd_valid  out  1  control-bus write request.
REQ-009 ctrl_cmd_address  out  16  control register address (0x0000 reset state, 0x0004 override cmd, 0x0008 override addr).
REQ-010 ctrl_cmd_data  out  32  write data.
REQ-011 ctrl_cmd_write  out  1  high whenever ctrl_cmd_valid high.
REQ-012 ctrl_cmd_ack  in  1  write accepted this cycle.

Function
REQ-013 Bus write: valid/address/data/write SHALL stay stable until the cycle ctrl_cmd_ack=1; the write completes that cycle; next write no earlier than following cycle.
REQ-014 States SHALL be IDLE, WR (issue write), WAIT (count), DONE; sequence step index selects write content and wait length.
REQ-015 IDLE->WR on start_i; start_i ignored while busy_o=1; start_i in DONE restarts from step 1 and clears done_o.
REQ-016 Step list (write -> then wait): 1 0x0000<=0x00000000 -> T_RESET_CYC; 2 0x0000<=0x00000003 -> T_CKE_CYC; 3 0x0000<=0x00000023 -> T_XPR_CYC.
REQ-017 Then for MR2, MR3, MR1, MR0 in that order: 0x0008<={bank,16'h0000-padded,MRn_VAL} with bank n in bits[31:32-BANK_BITS] and MRn_VAL in bits[15:0], no wait; then 0x0004<=0x00000000 (MRS) -> T_MOD_CYC.
REQ-018 Final step: 0x0000<=0x0000002B (reset_n, phy_reset_n, non-bypass, CKE) -> DONE, no wait.
REQ-019 WAIT of N SHALL last exactly max(N,1) cycles after the ack cycle; counter 32-bit, loads on ack, decrements to terminal.
REQ-020 busy_o=1 in WR and WAIT; done_o=1 only in DONE; both 0 in IDLE.
REQ-021 ctrl_cmd_ack while ctrl_cmd_valid=0 SHALL be ignored.

Reset
REQ-022 reset_i asserted at any time (incl. mid-write or mid-wait): state IDLE, step 0, counter 0, ctrl_cmd_valid=0, ctrl_cmd_write=0, address/data 0, busy_o=0, done_o=0, immediately and asynchronously.
REQ-023 After reset release, no bus write until start_i.

Configuration
REQ-024 SDDR_INIT_SEQ_ZQCL_EN defined: after MR0 wait, insert 0x0008<=0x00000400 (A10), then 0x0004<=0x00000006 (ZQCL) -> T_ZQINIT_CYC, before final step; 14 writes total.
REQ-025 Macro undefined: ZQCL steps absent, final step follows MR0 wait; 12 writes total; no ZQ logic synthesized.

Verification
REQ-026 Params T_RESET=4,T_CKE=5,T_XPR=3,T_MOD=2,T_ZQINIT=6, ack always 1, start pulse -> write sequence/data exactly per REQ-016..018 (+REQ-024 if enabled), done_o rises, count 12/14 writes.
REQ-027 MR1_VAL=16'h0044, BANK_BITS=3 -> third MR addr write data 0x20000044.
REQ-028 ack delayed 3 cycles on each write -> valid/address/data held constant, no write skipped or duplicated.
REQ-029 reset_i pulsed during T_CKE wait -> valid=0, busy=0 same cycle; new start -> sequence restarts at step 1 (data 0x00000000).
REQ-030 start_i pulsed while busy -> no effect; start_i in DONE -> done_o=0 next cycle, step 1 reissued.
REQ-031 Wait-length check: cycles between acks of step 1 and step 2 = T_RESET_CYC+1; with T_MOD_CYC=0 -> 1 wait cycle.
